// File: rtl/servo_angle_sequencer.sv
// Servo angle command sequencer: queues angle commands in a small FIFO and holds
// each one on the PWM angle select for a fixed number of 20 ms frames.
module servo_angle_sequencer #(
    parameter int frame_clock_cycles_p = 1000000,
    parameter int dwell_frames_p       = 25,
    parameter int fifo_depth_p         = 4,
    parameter int release_on_empty_p   = 0,
    parameter int mux_sel_length_p     = 2
) (
    input  logic                            Clk_i,
    input  logic                            Reset_i,
    input  logic                            Cmd_valid_i,
    input  logic [mux_sel_length_p-1:0]     Cmd_angle_i,
    output logic                            Cmd_ready_o,
    input  logic                            Abort_i,
    output logic [mux_sel_length_p-1:0]     Sel_angle_o,
    output logic                            Busy_o,
    output logic [$clog2(fifo_depth_p):0]   Fifo_count_o
);

    localparam int ptr_w_c   = (fifo_depth_p > 1) ? $clog2(fifo_depth_p) : 1;
    localparam int cnt_w_c   = $clog2(fifo_depth_p) + 1;
    localparam int frame_w_c = (frame_clock_cycles_p > 1) ? $clog2(frame_clock_cycles_p) : 1;
    localparam int dwell_w_c = (dwell_frames_p > 1) ? $clog2(dwell_frames_p) : 1;

    localparam logic [frame_w_c-1:0] frame_last_c = frame_w_c'(frame_clock_cycles_p - 1);
    localparam logic [dwell_w_c-1:0] dwell_last_c = dwell_w_c'(dwell_frames_p - 1);
    localparam logic [ptr_w_c-1:0]   ptr_last_c   = ptr_w_c'(fifo_depth_p - 1);
    localparam logic [cnt_w_c-1:0]   depth_c      = cnt_w_c'(fifo_depth_p);

    typedef enum logic [0:0] {IDLE = 1'b0, DWELL = 1'b1} state_t;

    state_t                        state_r;
    logic [mux_sel_length_p-1:0]   fifo_mem_r [fifo_depth_p];
    logic [ptr_w_c-1:0]            wr_ptr_r;
    logic [ptr_w_c-1:0]            rd_ptr_r;
    logic [cnt_w_c-1:0]            count_r;
    logic [frame_w_c-1:0]          frame_cnt_r;
    logic [dwell_w_c-1:0]          dwell_cnt_r;
    logic [mux_sel_length_p-1:0]   sel_r;
    logic                          busy_r;
    logic                          ready_r;

    logic                          push_s;
    logic                          pop_s;
    logic                          frame_end_s;
    logic                          dwell_end_s;
    logic [cnt_w_c-1:0]            count_next_s;
    logic [mux_sel_length_p-1:0]   head_s;

    function automatic logic [ptr_w_c-1:0] next_ptr(input logic [ptr_w_c-1:0] ptr);
        return (ptr == ptr_last_c) ? {ptr_w_c{1'b0}} : ptr + ptr_w_c'(1);
    endfunction

    // Handshake, pop decision and next FIFO occupancy; abort overrides everything.
    always_comb begin
        push_s       = Cmd_valid_i & ready_r & ~Abort_i;
        frame_end_s  = (frame_cnt_r == frame_last_c);
        dwell_end_s  = (state_r == DWELL) && frame_end_s && (dwell_cnt_r == dwell_last_c);
        pop_s        = ~Abort_i && (count_r != {cnt_w_c{1'b0}}) &&
                       ((state_r == IDLE) || dwell_end_s);
        head_s       = fifo_mem_r[rd_ptr_r];
        if (Abort_i) begin
            count_next_s = {cnt_w_c{1'b0}};
        end else begin
            count_next_s = count_r + cnt_w_c'(push_s) - cnt_w_c'(pop_s);
        end
    end

    // Command storage; occupancy and pointers guard validity, so no reset is needed.
    always_ff @(posedge Clk_i) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= Cmd_angle_i;
        end
    end

    // Sequencer FSM with FIFO pointers, dwell timing and all registered outputs.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_r     <= IDLE;
            wr_ptr_r    <= {ptr_w_c{1'b0}};
            rd_ptr_r    <= {ptr_w_c{1'b0}};
            count_r     <= {cnt_w_c{1'b0}};
            frame_cnt_r <= {frame_w_c{1'b0}};
            dwell_cnt_r <= {dwell_w_c{1'b0}};
            sel_r       <= {mux_sel_length_p{1'b0}};
            busy_r      <= 1'b0;
            ready_r     <= 1'b0;
        end else if (Abort_i) begin
            state_r     <= IDLE;
            wr_ptr_r    <= {ptr_w_c{1'b0}};
            rd_ptr_r    <= {ptr_w_c{1'b0}};
            count_r     <= {cnt_w_c{1'b0}};
            frame_cnt_r <= {frame_w_c{1'b0}};
            dwell_cnt_r <= {dwell_w_c{1'b0}};
            sel_r       <= {mux_sel_length_p{1'b0}};
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            count_r <= count_next_s;
            ready_r <= (count_next_s < depth_c);
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        sel_r       <= head_s;
                        frame_cnt_r <= {frame_w_c{1'b0}};
                        dwell_cnt_r <= {dwell_w_c{1'b0}};
                        state_r     <= DWELL;
                        busy_r      <= 1'b1;
                    end
                end
                DWELL: begin
                    if (dwell_end_s) begin
                        frame_cnt_r <= {frame_w_c{1'b0}};
                        dwell_cnt_r <= {dwell_w_c{1'b0}};
                        if (pop_s) begin
                            sel_r <= head_s;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            if (release_on_empty_p != 0) begin
                                sel_r <= {mux_sel_length_p{1'b0}};
                            end
                        end
                    end else if (frame_end_s) begin
                        frame_cnt_r <= {frame_w_c{1'b0}};
                        dwell_cnt_r <= dwell_cnt_r + dwell_w_c'(1);
                    end else begin
                        frame_cnt_r <= frame_cnt_r + frame_w_c'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Cmd_ready_o  = ready_r;
    assign Sel_angle_o  = sel_r;
    assign Busy_o       = busy_r;
    assign Fifo_count_o = count_r;

endmodule

// File: tb/tb_servo_angle_sequencer.sv
// Bench for servo_angle_sequencer: two instances (hold / release on empty) driven
// identically and compared each cycle against a queue-based reference model.
module tb_servo_angle_sequencer;

    localparam int F     = 10;
    localparam int D     = 2;
    localparam int DEPTH = 4;
    localparam int HOLD  = F * D;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       abort;
    logic [1:0] angle;
    logic       ready0, ready1, busy0, busy1;
    logic [1:0] sel0, sel1;
    logic [2:0] cnt0, cnt1;

    always #5 clk = ~clk;

    servo_angle_sequencer #(
        .frame_clock_cycles_p(F), .dwell_frames_p(D), .fifo_depth_p(DEPTH),
        .release_on_empty_p(0), .mux_sel_length_p(2)
    ) dut0 (
        .Clk_i(clk), .Reset_i(rst), .Cmd_valid_i(valid), .Cmd_angle_i(angle),
        .Cmd_ready_o(ready0), .Abort_i(abort), .Sel_angle_o(sel0),
        .Busy_o(busy0), .Fifo_count_o(cnt0)
    );

    servo_angle_sequencer #(
        .frame_clock_cycles_p(F), .dwell_frames_p(D), .fifo_depth_p(DEPTH),
        .release_on_empty_p(1), .mux_sel_length_p(2)
    ) dut1 (
        .Clk_i(clk), .Reset_i(rst), .Cmd_valid_i(valid), .Cmd_angle_i(angle),
        .Cmd_ready_o(ready1), .Abort_i(abort), .Sel_angle_o(sel1),
        .Busy_o(busy1), .Fifo_count_o(cnt1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending commands, shown angle per instance, cycles left in dwell.
    int q[$];
    int m_sel0, m_sel1, m_busy, m_rem, m_ready;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sel0  = 0;
        m_sel1  = 0;
        m_busy  = 0;
        m_rem   = 0;
        m_ready = 0;
    endtask

    task automatic model_step();
        int accept;
        if (rst) begin
            model_reset();
        end else if (abort) begin
            q.delete();
            m_sel0  = 0;
            m_sel1  = 0;
            m_busy  = 0;
            m_rem   = 0;
            m_ready = 1;
        end else begin
            accept = (valid && m_ready) ? 1 : 0;
            if (q.size() > 0 && (m_busy == 0 || m_rem == 1)) begin
                m_sel0 = q.pop_front();
                m_sel1 = m_sel0;
                m_busy = 1;
                m_rem  = HOLD;
            end else if (m_busy != 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_sel1 = 0;
                end
            end
            if (accept != 0) q.push_back(int'(angle));
            m_ready = (q.size() < DEPTH) ? 1 : 0;
        end
    endtask

    task automatic check_all();
        check_value("sel_hold",    32'(sel0),   m_sel0);
        check_value("sel_release", 32'(sel1),   m_sel1);
        check_value("busy0",       32'(busy0),  m_busy);
        check_value("busy1",       32'(busy1),  m_busy);
        check_value("count0",      32'(cnt0),   q.size());
        check_value("count1",      32'(cnt1),   q.size());
        check_value("ready0",      32'(ready0), m_ready);
        check_value("ready1",      32'(ready1), m_ready);
    endtask

    task automatic cycle(input logic v, input logic [1:0] a, input logic ab);
        @(negedge clk);
        valid = v;
        angle = a;
        abort = ab;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        int busy_cycles;
        int seen;
        rst   = 1'b1;
        valid = 1'b0;
        angle = 2'd0;
        abort = 1'b0;
        model_reset();

        repeat (2) cycle(1'b0, 2'd0, 1'b0);
        check_value("reset_ready", 32'(ready0), 0);
        check_value("reset_sel",   32'(sel0),   0);
        rst = 1'b0;
        cycle(1'b0, 2'd0, 1'b0);
        check_value("ready_after_reset", 32'(ready0), 1);

        // Single command: visible one edge after acceptance, held for a full dwell.
        cycle(1'b1, 2'd2, 1'b0);
        check_value("latency_T", 32'(sel0), 0);
        cycle(1'b0, 2'd0, 1'b0);
        check_value("latency_T1", 32'(sel0), 2);
        repeat (HOLD - 1) cycle(1'b0, 2'd0, 1'b0);
        check_value("busy_last", 32'(busy0), 1);
        cycle(1'b0, 2'd0, 1'b0);
        check_value("idle_busy",    32'(busy0), 0);
        check_value("idle_hold",    32'(sel0),  2);
        check_value("idle_release", 32'(sel1),  0);

        // Back-to-back commands with no idle gap.
        cycle(1'b1, 2'd1, 1'b0);
        cycle(1'b1, 2'd3, 1'b0);
        cycle(1'b1, 2'd2, 1'b0);
        busy_cycles = 0;
        repeat (70) begin
            cycle(1'b0, 2'd0, 1'b0);
            if (busy0) busy_cycles++;
        end
        check_value("b2b_busy_cycles", busy_cycles, 3 * HOLD - 2);

        // Full FIFO: four queued behind a dwelling command, fifth refused.
        cycle(1'b1, 2'd1, 1'b0);
        cycle(1'b0, 2'd0, 1'b0);
        cycle(1'b1, 2'd2, 1'b0);
        cycle(1'b1, 2'd3, 1'b0);
        cycle(1'b1, 2'd1, 1'b0);
        cycle(1'b1, 2'd2, 1'b0);
        cycle(1'b1, 2'd3, 1'b0);
        check_value("full_count", 32'(cnt0),   4);
        check_value("full_ready", 32'(ready0), 0);
        seen = 0;
        for (int i = 0; i < 3 * HOLD && seen == 0; i++) begin
            cycle(1'b0, 2'd0, 1'b0);
            if (cnt0 == 3'd3) begin
                seen = 1;
                check_value("ready_after_pop", 32'(ready0), 1);
            end
        end
        check_value("pop_seen", seen, 1);
        cycle(1'b0, 2'd0, 1'b1);

        // Abort mid-dwell with two commands queued.
        cycle(1'b1, 2'd1, 1'b0);
        cycle(1'b1, 2'd2, 1'b0);
        cycle(1'b1, 2'd3, 1'b0);
        repeat (6) cycle(1'b0, 2'd0, 1'b0);
        check_value("pre_abort_count", 32'(cnt0), 2);
        cycle(1'b0, 2'd0, 1'b1);
        check_value("abort_sel",   32'(sel0),  0);
        check_value("abort_count", 32'(cnt0),  0);
        check_value("abort_busy",  32'(busy0), 0);

        // Abort beats a simultaneous push.
        cycle(1'b1, 2'd3, 1'b1);
        check_value("abort_wins", 32'(cnt0), 0);
        cycle(1'b0, 2'd0, 1'b0);
        check_value("abort_wins_idle", 32'(busy0), 0);

        // Asynchronous reset mid-dwell takes effect without a clock edge.
        cycle(1'b1, 2'd3, 1'b0);
        repeat (5) cycle(1'b0, 2'd0, 1'b0);
        cycle(1'b1, 2'd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_value("async_sel0",  32'(sel0),   0);
        check_value("async_sel1",  32'(sel1),   0);
        check_value("async_busy",  32'(busy1),  0);
        check_value("async_count", 32'(cnt1),   0);
        check_value("async_ready", 32'(ready1), 0);
        model_reset();
        cycle(1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        cycle(1'b0, 2'd0, 1'b0);
        cycle(1'b0, 2'd0, 1'b0);
        check_value("reset_discards", 32'(busy0), 0);

        // Randomized traffic against the model.
        repeat (1500) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
